// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of the UART transmitter, one enable pulse per byte.
// Define UART_TX_FIFO_OVF_EN to add the refused-push counter and sticky flag.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  tx_enable,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic [15:0]           ovf_count,
    output logic                  ovf_sticky
`endif
);

    localparam int WCW = $clog2(BUSY_WAIT + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   ZERO_LEVEL  = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [WCW-1:0]        WC_ONE      = {{(WCW-1){1'b0}}, 1'b1};
    localparam logic [WCW-1:0]        BUSY_WAIT_C = WCW'(BUSY_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [WCW-1:0]          wait_cnt_r, wait_cnt_s;
    logic [DEPTH_LOG2-1:0]   wr_ptr_r, rd_ptr_r;
    logic [DEPTH_LOG2:0]     level_r, level_s;
    logic                    empty_r, full_r, in_ready_r;
    logic                    tx_enable_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic                    push_s, pop_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    // Handshake FSM: pop only from IDLE with the transmitter free, then wait for busy to cycle.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r && !tx_busy) begin
                    pop_s      = 1'b1;
                    wait_cnt_s = {WCW{1'b0}};
                    state_s    = ST_LAUNCH;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (tx_busy) begin
                    state_s = ST_SEND;
                end else begin
                    // A transmitter that never raises busy still frees the FSM; the byte counts as sent.
                    wait_cnt_s = wait_cnt_r + WC_ONE;
                    if (wait_cnt_s == BUSY_WAIT_C) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LAUNCH;
                    end
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                wait_cnt_s = {WCW{1'b0}};
            end
        endcase
    end

    // Occupancy bookkeeping; acceptance uses the registered ready so a same-cycle pop never admits a push at full.
    always_comb begin
        push_s  = in_valid && in_ready_r;
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_ONE;
            2'b01:   level_s = level_r - LVL_ONE;
            default: level_s = level_r;
        endcase
    end

    // Control registers and the transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= {WCW{1'b0}};
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            level_r     <= ZERO_LEVEL;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            tx_enable_r <= 1'b0;
            tx_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            level_r     <= level_s;
            empty_r     <= (level_s == ZERO_LEVEL);
            full_r      <= (level_s == FULL_LEVEL);
            in_ready_r  <= (level_s != FULL_LEVEL);
            tx_enable_r <= pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    assign in_ready  = in_ready_r;
    assign tx_enable = tx_enable_r;
    assign tx_data   = tx_data_r;
    assign level     = level_r;
    assign empty     = empty_r;
    assign full      = full_r;

`ifdef UART_TX_FIFO_OVF_EN
    logic [15:0] ovf_count_r;
    logic        ovf_sticky_r;

    // Refused-push statistics: saturating count plus a flag that only reset clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_count_r  <= 16'h0000;
            ovf_sticky_r <= 1'b0;
        end else if (in_valid && !in_ready_r) begin
            if (ovf_count_r != 16'hFFFF) begin
                ovf_count_r <= ovf_count_r + 16'd1;
            end
            ovf_sticky_r <= 1'b1;
        end
    end

    assign ovf_count  = ovf_count_r;
    assign ovf_sticky = ovf_sticky_r;
`endif

endmodule
